// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Holds the program counter and the IF/ID pipeline register. Obeys the
// hazard unit's stall requests and applies the branch/jump redirects
// resolved in ID, flushing the wrong-path instruction that was fetched in
// the same cycle. Two saturating event counters expose stall and flush
// activity for performance debug.
//
// Parameters
//   RESET_PC        PC value loaded on reset
//   CNT_W           width of stall_count / flush_count
//
// Ports
//   clk             pipeline clock, all state changes on the rising edge
//   reset           synchronous, active-high reset
//   pc_stall        hazard unit: hold the PC
//   IF_ID_stall     hazard unit: hold the IF/ID register
//   branch_taken    ID: branch resolved taken this cycle
//   branch_target   branch destination byte address
//   jump            ID: unconditional jump this cycle
//   jump_target     jump destination byte address
//   imem_rdata      instruction word at imem_addr (combinational memory)
//   imem_addr       current PC
//   IF_ID_instr     latched instruction to ID
//   IF_ID_pc_plus4  latched PC+4 to ID
//   IF_ID_valid     1 = real instruction, 0 = bubble
//   stall_count     saturating count of pc_stall cycles
//   flush_count     saturating count of IF/ID flushes
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_stall,
  input  logic             IF_ID_stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      IF_ID_instr,
  output logic [31:0]      IF_ID_pc_plus4,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      NOP     = 32'h0000_0000;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        redirect;
  logic        flush;

  // Targets are forced word aligned, so their low two bits never matter.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^{branch_target[1:0], jump_target[1:0]};

  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;

  // A redirect presented while the PC is stalled is dropped here; ID keeps
  // holding the branch and presents it again once the stall releases.
  assign redirect = (branch_taken | jump) & ~pc_stall;
  assign flush    = redirect & ~IF_ID_stall;

  always_comb begin
    pc_next = pc_plus4;
    if (pc_stall) begin
      pc_next = pc_q;
    end else if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (jump) begin
      pc_next = {jump_target[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      IF_ID_instr    <= NOP;
      IF_ID_pc_plus4 <= 32'h0000_0000;
      IF_ID_valid    <= 1'b0;
      stall_count    <= '0;
      flush_count    <= '0;
    end else begin
      pc_q <= pc_next;

      // pc_stall without IF_ID_stall simply re-latches the same PC.
      if (!IF_ID_stall) begin
        if (redirect) begin
          IF_ID_instr    <= NOP;
          IF_ID_pc_plus4 <= 32'h0000_0000;
          IF_ID_valid    <= 1'b0;
        end else begin
          IF_ID_instr    <= imem_rdata;
          IF_ID_pc_plus4 <= pc_plus4;
          IF_ID_valid    <= 1'b1;
        end
      end

      if (pc_stall && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end

      if (flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule
